// File: rtl/clk_div_ctrl_if.sv
// +----------------------------------------------------------------------+
// | clk_div_ctrl_if : ratio-configuration handshake for clk_div_ctrl      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface clk_div_ctrl_if #(
  parameter int CNT_W = 8
) ();
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// +----------------------------------------------------------------------+
// | clk_div_ctrl : programmable divider with tick strobe and deferred     |
// | ratio updates. Optional tick counter enabled by macro TICK_CNT_EN.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_en,
  clk_div_ctrl_if.slave         cfg,
  output logic                  o_tick,
  output logic                  o_div_out,
  output logic [CNT_W-1:0]      o_cur_div,
  output logic                  o_busy,
  output logic [15:0]           o_tick_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_DEFAULT_DIV = CNT_W'(DEFAULT_DIV);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_cur_div;
  logic [CNT_W-1:0] r_pend_div;
  logic             r_tick;
  logic             r_div_out;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_cur_nxt;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             w_tick_nxt;
  logic             w_div_nxt;
  logic             w_ready;
  logic             w_accept;
  logic             w_terminal;

  assign w_ready    = (r_state != S_PEND);
  assign w_accept   = cfg.cfg_valid && w_ready;
  assign w_terminal = (r_count == r_cur_div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_cur_div  <= c_DEFAULT_DIV;
      r_pend_div <= '0;
      r_tick     <= 1'b0;
      r_div_out  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_cur_div  <= w_cur_nxt;
      r_pend_div <= w_pend_nxt;
      r_tick     <= w_tick_nxt;
      r_div_out  <= w_div_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_cur_nxt   = r_cur_div;
    w_pend_nxt  = r_pend_div;
    w_tick_nxt  = 1'b0;
    w_div_nxt   = r_div_out;
    case (r_state)
      S_IDLE: begin
        w_count_nxt = '0;
        w_div_nxt   = 1'b0;
        if (w_accept) w_cur_nxt = cfg.cfg_div;
        if (i_en) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!i_en) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
          w_div_nxt   = 1'b0;
          if (w_accept) w_cur_nxt = cfg.cfg_div;
        end else begin
          if (w_terminal) begin
            w_count_nxt = '0;
            w_tick_nxt  = 1'b1;
            w_div_nxt   = ~r_div_out;
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
          // A ratio accepted on a terminal cycle waits for the next terminal
          if (w_accept) begin
            w_pend_nxt  = cfg.cfg_div;
            w_state_nxt = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (!i_en) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
          w_div_nxt   = 1'b0;
          w_cur_nxt   = r_pend_div;
        end else if (w_terminal) begin
          w_state_nxt = S_RUN;
          w_count_nxt = '0;
          w_tick_nxt  = 1'b1;
          w_div_nxt   = ~r_div_out;
          w_cur_nxt   = r_pend_div;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
        w_div_nxt   = 1'b0;
      end
    endcase
  end

`ifdef TICK_CNT_EN
  logic [15:0] r_tick_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (r_tick) begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  assign o_tick_cnt = r_tick_cnt;
`else
  assign o_tick_cnt = '0;
`endif

  assign cfg.cfg_ready = w_ready;
  assign o_tick        = r_tick;
  assign o_div_out     = r_div_out;
  assign o_cur_div     = r_cur_div;
  assign o_busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Programmable clock-divider controller generating a divided square wave and a one-cycle tick strobe from clk. Divide ratio is reconfigured through a valid/ready handshake. Changes issued while running are deferred to the next terminal count, so the output never produces a runt period. Sits between software-visible config logic and downstream blocks that consume divided ticks/clocks-as-data.

Parameters:
CNT_W, 8, width of divide-ratio value and internal counter
DEFAULT_DIV, 1, cur_div value loaded at reset (must fit CNT_W)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
en  input  1  run enable; level-sensitive
cfg_valid  input  1  new ratio offered
cfg_div  input  CNT_W  requested ratio N; tick period = N+1 clk cycles
cfg_ready  output  1  controller can accept cfg this cycle
tick  output  1  one-cycle pulse at each terminal count, registered
div_out  output  1  square wave toggling at each terminal count; period 2*(cur_div+1)
cur_div  output  CNT_W  ratio currently in effect
busy  output  1  high when state != IDLE
tick_cnt  output  16  tick counter (see Optional Feature)

Behaviour:
- Reset (rst low, async): state=IDLE, count=0, cur_div=DEFAULT_DIV, pend_div=0, tick=0, div_out=0, tick_cnt=0. cfg_ready=1 from first cycle after release.
- States: IDLE, RUN, PEND. cfg_ready = (state != PEND), combinational from state.
- Accept = cfg_valid && cfg_ready.
- IDLE: count held 0, tick=0, div_out=0. Accept -> cur_div<=cfg_div next cycle. en=1 -> RUN next cycle, count starts at 0.
- RUN: count increments each cycle. When count==cur_div (terminal): count<=0, tick<=1 for one cycle, div_out<=~div_out. First tick asserts cur_div+1 cycles after entering RUN. cur_div=0 -> tick high every cycle, div_out toggles every cycle.
- RUN + accept -> pend_div<=cfg_div, state->PEND. If accept coincides with terminal, that terminal uses the old ratio; the new ratio applies at the following terminal.
- PEND: counting continues with old cur_div. At terminal: cur_div<=pend_div, count<=0, tick, toggle, state->RUN. cfg_ready=0 throughout PEND; offered cfg must be held by source.
- en low in RUN/PEND -> IDLE next cycle: count<=0, div_out<=0, tick<=0; if in PEND, cur_div<=pend_div immediately (pending cfg never lost).
- en low and accept in same RUN cycle -> IDLE with cur_div<=cfg_div.
- Counter never exceeds cur_div; ratio only changes while count==0 boundary or in IDLE.
- Reset mid-operation: all state abandoned, pending cfg discarded, cur_div returns to DEFAULT_DIV.

Optional Feature:
TICK_CNT_EN: when defined, tick_cnt increments by 1 on every cycle tick is high, wraps 16'hFFFF->0, cleared by reset only (not by en). When undefined, tick_cnt is tied to 0 and no counter is built.

Test Plan:
- Reset, en=1, default DEFAULT_DIV=1 -> tick every 2 cycles, div_out period 4, busy=1, cur_div=1.
- IDLE, cfg_div=4 accepted, en=1 -> first tick 5 cycles after RUN entry, then every 5; div_out period 10.
- RUN with cur_div=7, cfg_div=2 accepted at count=3 -> cfg_ready=0 until terminal at count=7; ticks then every 3 cycles; no period shorter than 3 or between 3 and 8.
- PEND with pending 2, drop en -> IDLE next cycle, div_out=0, cur_div=2, cfg_ready=1.
- cfg_div=0 in RUN -> after the boundary, tick constantly high, div_out toggles every cycle; TICK_CNT_EN build: tick_cnt increments every cycle and wraps at 65536.
- Assert rst low mid-PEND -> all outputs at reset values asynchronously, cur_div=DEFAULT_DIV, pending ratio discarded.
